// File: rtl/scatter_packet_tx_if.sv
// Packet link between the scatter transmitter and the scatter receiver.
// A packet transfers on every rising clock edge where out_valid && out_ready.
// The master holds out_data and out_valid steady until the transfer happens.
// out_valid never depends on out_ready.
interface scatter_packet_tx_if;
    logic         out_valid;
    logic [127:0] out_data;
    logic         out_ready;

    modport master (output out_valid, output out_data, input out_ready);
    modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/scatter_packet_tx.sv
// scatter_packet_tx: builds weight, bias and image packets for one channel load
// from the on-chip source memories and streams them through a 2-entry buffer.
// Optional feature macro: PKT_COUNT_EN adds pkt_count, the number of packets
// accepted in the current load (saturating at 65535).
module scatter_packet_tx #(
    parameter int NUM_PUS        = 64,
    parameter int ADDR_WIDTH     = 8,
    parameter int IMG_ADDR_WIDTH = 12,
    parameter int DATA_WIDTH     = 8,
    parameter int WEIGHT_WIDTH   = 16,
    parameter int BIAS_WIDTH     = 32,
    parameter int IMG_SIZE       = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [7:0]                cfg_channel,
    input  logic [6:0]                cfg_num_pus,
    input  logic [7:0]                cfg_filter_base,
    input  logic                      cfg_send_bias,
    output logic                      busy,
    output logic                      done,
    output logic                      weight_rd_en,
    output logic [ADDR_WIDTH-1:0]     weight_rd_addr,
    input  logic [3*WEIGHT_WIDTH-1:0] weight_rd_data,
    output logic                      bias_rd_en,
    output logic [5:0]                bias_rd_addr,
    input  logic [BIAS_WIDTH-1:0]     bias_rd_data,
    output logic                      img_rd_en,
    output logic [IMG_ADDR_WIDTH-1:0] img_rd_addr,
    input  logic [DATA_WIDTH-1:0]     img_rd_data,
    scatter_packet_tx_if.master       pkt,
    output logic [2:0]                dbg_state
`ifdef PKT_COUNT_EN
    ,
    output logic [15:0]               pkt_count
`endif
);
    localparam int TOTAL_PIXELS = IMG_SIZE * IMG_SIZE;
    localparam logic [7:0] LAST_IDX = 8'(TOTAL_PIXELS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WEIGHT, S_BIAS, S_IMAGE, S_DRAIN, S_DONE
    } state_t;

    state_t       state, state_nx, cur_phase;
    logic [7:0]   ch_q, fbase_q, cur_ch, cur_fbase;
    logic [6:0]   npus_q, cur_npus, npus_clamped;
    logic         bias_q, cur_bias;
    logic [6:0]   pu_q, pu_nx;
    logic [1:0]   row_q, row_nx;
    logic [7:0]   idx_q, idx_nx;
    logic         issue, accept, slot_free;
    // one read in flight: its packet header fields wait here for the memory data
    logic         pend_valid_q;
    logic [1:0]   pend_type_q;
    logic [5:0]   pend_pu_q;
    logic [7:0]   pend_fid_q, pend_ch_q, pend_idx_q;
    logic [1:0]   pend_row_q;
    logic [127:0] wr_pkt;
    logic [127:0] buf_q [2];
    logic         rd_ptr_q, wr_ptr_q;
    logic [1:0]   count_q;

    assign accept       = pkt.out_valid && pkt.out_ready;
    // a slot vacated by this cycle's acceptance may be claimed by this cycle's read
    assign slot_free    = ({1'b0, count_q} + {2'b0, pend_valid_q}) < (3'd2 + {2'b0, accept});
    assign npus_clamped = (cfg_num_pus > 7'(NUM_PUS)) ? 7'(NUM_PUS) : cfg_num_pus;
    assign pkt.out_valid = (count_q != 2'd0);
    assign pkt.out_data  = buf_q[rd_ptr_q];
    assign busy      = (state == S_WEIGHT) || (state == S_BIAS) || (state == S_IMAGE) || (state == S_DRAIN);
    assign done      = (state == S_DONE);
    assign dbg_state = state;

    // The first read is issued in the start cycle itself, from the raw cfg inputs,
    // so the first packet is presented two cycles after start.
    always_comb begin
        state_nx  = state;
        pu_nx     = pu_q;
        row_nx    = row_q;
        idx_nx    = idx_q;
        cur_phase = state;
        cur_ch    = ch_q;
        cur_fbase = fbase_q;
        cur_npus  = npus_q;
        cur_bias  = bias_q;
        if (state == S_IDLE && start) begin
            cur_ch    = cfg_channel;
            cur_fbase = cfg_filter_base;
            cur_npus  = npus_clamped;
            cur_bias  = cfg_send_bias;
            cur_phase = (npus_clamped == 7'd0) ? S_IMAGE : S_WEIGHT;
            state_nx  = cur_phase;
        end
        issue = slot_free && (cur_phase == S_WEIGHT || cur_phase == S_BIAS || cur_phase == S_IMAGE);
        case (cur_phase)
            S_WEIGHT: if (issue) begin
                if (row_q == 2'd2) begin
                    row_nx = 2'd0;
                    if (pu_q == cur_npus - 7'd1) begin
                        pu_nx    = 7'd0;
                        state_nx = cur_bias ? S_BIAS : S_IMAGE;
                    end else begin
                        pu_nx = pu_q + 7'd1;
                    end
                end else begin
                    row_nx = row_q + 2'd1;
                end
            end
            S_BIAS: if (issue) begin
                if (pu_q == cur_npus - 7'd1) begin
                    pu_nx    = 7'd0;
                    state_nx = S_IMAGE;
                end else begin
                    pu_nx = pu_q + 7'd1;
                end
            end
            S_IMAGE: if (issue) begin
                if (idx_q == LAST_IDX) begin
                    idx_nx   = 8'd0;
                    state_nx = S_DRAIN;
                end else begin
                    idx_nx = idx_q + 8'd1;
                end
            end
            S_DRAIN: if (count_q == 2'd0 && !pend_valid_q) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            S_IDLE:  ;
            default: state_nx = S_IDLE;
        endcase
    end

    // Memory read strobes; addresses read as 0 whenever no read is issued.
    always_comb begin
        weight_rd_en   = issue && (cur_phase == S_WEIGHT);
        bias_rd_en     = issue && (cur_phase == S_BIAS);
        img_rd_en      = issue && (cur_phase == S_IMAGE);
        weight_rd_addr = weight_rd_en ? ADDR_WIDTH'({pu_q[5:0], row_q}) : '0;
        bias_rd_addr   = bias_rd_en ? pu_q[5:0] : 6'd0;
        img_rd_addr    = img_rd_en ? IMG_ADDR_WIDTH'(32'(cur_ch) * TOTAL_PIXELS + 32'(idx_q)) : '0;
    end

    // Assemble the packet from the returned memory word and the held header fields.
    always_comb begin
        wr_pkt = '0;
        case (pend_type_q)
            2'b10: wr_pkt = {2'b10, pend_pu_q, pend_fid_q, pend_ch_q,
                             6'd0, pend_row_q, weight_rd_data[WEIGHT_WIDTH-1:0],
                             6'd0, pend_row_q, weight_rd_data[2*WEIGHT_WIDTH-1:WEIGHT_WIDTH],
                             6'd0, pend_row_q, weight_rd_data[3*WEIGHT_WIDTH-1:2*WEIGHT_WIDTH],
                             32'd0};
            2'b01: wr_pkt = {2'b01, pend_pu_q, pend_fid_q, pend_ch_q, 8'd0, bias_rd_data, 64'd0};
            default: wr_pkt = {2'b00, 6'd0, 8'd0, pend_ch_q, pend_idx_q, img_rd_data, 88'd0};
        endcase
    end

    // FSM state, phase counters and latched load configuration.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            pu_q    <= 7'd0;
            row_q   <= 2'd0;
            idx_q   <= 8'd0;
            ch_q    <= 8'd0;
            fbase_q <= 8'd0;
            npus_q  <= 7'd0;
            bias_q  <= 1'b0;
        end else begin
            state   <= state_nx;
            pu_q    <= pu_nx;
            row_q   <= row_nx;
            idx_q   <= idx_nx;
            ch_q    <= cur_ch;
            fbase_q <= cur_fbase;
            npus_q  <= cur_npus;
            bias_q  <= cur_bias;
        end
    end

    // Header fields of the read in flight, captured when the read is issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_valid_q <= 1'b0;
            pend_type_q  <= 2'b00;
            pend_pu_q    <= 6'd0;
            pend_fid_q   <= 8'd0;
            pend_ch_q    <= 8'd0;
            pend_row_q   <= 2'd0;
            pend_idx_q   <= 8'd0;
        end else begin
            pend_valid_q <= issue;
            if (issue) begin
                pend_type_q <= (cur_phase == S_WEIGHT) ? 2'b10 : (cur_phase == S_BIAS) ? 2'b01 : 2'b00;
                pend_pu_q   <= (cur_phase == S_IMAGE) ? 6'd0 : pu_q[5:0];
                pend_fid_q  <= (cur_phase == S_IMAGE) ? 8'd0 : cur_fbase + {1'b0, pu_q};
                pend_ch_q   <= cur_ch;
                pend_row_q  <= row_q;
                pend_idx_q  <= idx_q;
            end
        end
    end

    // Two-entry output buffer; the head entry drives out_data.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_q[0] <= '0;
            buf_q[1] <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (pend_valid_q) begin
                buf_q[wr_ptr_q] <= wr_pkt;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (accept) rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_q + {1'b0, pend_valid_q} - {1'b0, accept};
        end
    end

`ifdef PKT_COUNT_EN
    // Accepted packets of the current load; cleared by start, saturates, held after done.
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_count <= 16'd0;
        end else if (state == S_IDLE && start) begin
            pkt_count <= 16'd0;
        end else if (accept && pkt_count != 16'hFFFF) begin
            pkt_count <= pkt_count + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_scatter_packet_tx.sv
// Bench for scatter_packet_tx: memory models, load driver, packet scoreboard.
module tb_scatter_packet_tx;
    localparam int TP = 100;

    logic         clk = 1'b0;
    logic         rst, start;
    logic [7:0]   cfg_channel, cfg_filter_base;
    logic [6:0]   cfg_num_pus;
    logic         cfg_send_bias;
    logic         busy, done;
    logic         weight_rd_en, bias_rd_en, img_rd_en;
    logic [7:0]   weight_rd_addr;
    logic [47:0]  weight_rd_data;
    logic [5:0]   bias_rd_addr;
    logic [31:0]  bias_rd_data;
    logic [11:0]  img_rd_addr;
    logic [7:0]   img_rd_data;
    logic [2:0]   dbg_state;
`ifdef PKT_COUNT_EN
    logic [15:0]  pkt_count;
`endif

    scatter_packet_tx_if pkt_if();

    scatter_packet_tx dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_channel(cfg_channel), .cfg_num_pus(cfg_num_pus),
        .cfg_filter_base(cfg_filter_base), .cfg_send_bias(cfg_send_bias),
        .busy(busy), .done(done),
        .weight_rd_en(weight_rd_en), .weight_rd_addr(weight_rd_addr), .weight_rd_data(weight_rd_data),
        .bias_rd_en(bias_rd_en), .bias_rd_addr(bias_rd_addr), .bias_rd_data(bias_rd_data),
        .img_rd_en(img_rd_en), .img_rd_addr(img_rd_addr), .img_rd_data(img_rd_data),
        .pkt(pkt_if.master), .dbg_state(dbg_state)
`ifdef PKT_COUNT_EN
        , .pkt_count(pkt_count)
`endif
    );

    // clock / reset
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [127:0] exp_q[$];
    int cyc = 0;
    int acc_cnt = 0;
    int done_cnt = 0;
    int ready_mode = 0;
    int start_cyc, first_valid_cyc, first_acc_cyc, last_acc_cyc;
    logic seen_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [47:0] wmem(input logic [7:0] a);
        return {a, 8'h33, a, 8'h22, a, 8'h11};
    endfunction
    function automatic logic [31:0] bmem(input logic [5:0] a);
        return {16'hB15A, 8'h00, 2'b00, a};
    endfunction
    function automatic logic [7:0] pmem(input logic [11:0] a);
        return a[7:0] + {4'h0, a[11:8]};
    endfunction

    // source memories: one cycle read latency
    always @(posedge clk) begin
        if (weight_rd_en) weight_rd_data <= wmem(weight_rd_addr);
        if (bias_rd_en)   bias_rd_data   <= bmem(bias_rd_addr);
        if (img_rd_en)    img_rd_data    <= pmem(img_rd_addr);
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // expected packet sequence of one load
    task automatic push_load(input logic [7:0] ch, input logic [6:0] n, input logic [7:0] fb,
                             input logic sb, output int cnt);
        logic [7:0]  a;
        logic [47:0] w;
        logic [11:0] ia;
        cnt = 0;
        for (int p = 0; p < int'(n); p++) begin
            for (int r = 0; r < 3; r++) begin
                a = {p[5:0], r[1:0]};
                w = wmem(a);
                exp_q.push_back({2'b10, p[5:0], 8'(fb + p), ch, 8'(r), w[15:0], 8'(r), w[31:16],
                                 8'(r), w[47:32], 32'd0});
                cnt++;
            end
        end
        if (sb) begin
            for (int p = 0; p < int'(n); p++) begin
                exp_q.push_back({2'b01, p[5:0], 8'(fb + p), ch, 8'd0, bmem(p[5:0]), 64'd0});
                cnt++;
            end
        end
        for (int i = 0; i < TP; i++) begin
            ia = 12'(int'(ch) * TP + i);
            exp_q.push_back({2'b00, 6'd0, 8'd0, ch, 8'(i), pmem(ia), 88'd0});
            cnt++;
        end
    endtask

    // out_ready driver: 0 = always ready, 1 = toggle, 2 = random
    initial begin
        pkt_if.out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0: pkt_if.out_ready = 1'b1;
                1: pkt_if.out_ready = ~pkt_if.out_ready;
                default: pkt_if.out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // scoreboard: every presented packet must be the queue head, popped on acceptance
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (done) done_cnt++;
                if (pkt_if.out_valid) begin
                    if (!seen_valid) begin
                        seen_valid = 1'b1;
                        first_valid_cyc = cyc;
                    end
                    if (exp_q.size() == 0) begin
                        check("extra_pkt_valid", 128'(pkt_if.out_valid), 128'd0);
                    end else begin
                        check("pkt", pkt_if.out_data, exp_q[0]);
                        if (pkt_if.out_ready) begin
                            void'(exp_q.pop_front());
                            acc_cnt++;
                            if (acc_cnt == 1) first_acc_cyc = cyc;
                            last_acc_cyc = cyc;
                        end
                    end
                end
            end
        end
    end

    task automatic begin_load(input logic [7:0] ch, input logic [6:0] n, input logic [7:0] fb,
                              input logic sb, input int mode, output int exp_n);
        push_load(ch, n, fb, sb, exp_n);
        ready_mode = mode;
        acc_cnt = 0;
        seen_valid = 1'b0;
        @(posedge clk); #1;
        cfg_channel = ch; cfg_num_pus = n; cfg_filter_base = fb; cfg_send_bias = sb;
        start = 1'b1;
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        cfg_channel = 8'($urandom_range(0, 255));
        cfg_num_pus = 7'($urandom_range(0, 64));
        cfg_filter_base = 8'($urandom_range(0, 255));
        cfg_send_bias = 1'($urandom_range(0, 1));
        check("busy_after_start", 128'(busy), 128'd1);
    endtask

    task automatic do_load(input logic [7:0] ch, input logic [6:0] n, input logic [7:0] fb,
                           input logic sb, input int mode, input int spurious_at);
        int exp_n;
        int d0;
        d0 = done_cnt;
        begin_load(ch, n, fb, sb, mode, exp_n);
        for (int c = 0; c < 4000 && done_cnt == d0; c++) begin
            @(posedge clk); #1;
            start = (c == spurious_at);
        end
        start = 1'b0;
        check("done_seen", 128'(done_cnt - d0), 128'd1);
        check("pkts_left", 128'(exp_q.size()), 128'd0);
        check("pkts_accepted", 128'(acc_cnt), 128'(exp_n));
        if (mode == 0) begin
            check("first_valid_latency", 128'(first_valid_cyc - start_cyc), 128'd2);
            check("no_bubbles", 128'(last_acc_cyc - first_acc_cyc + 1), 128'(exp_n));
        end
        repeat (3) @(posedge clk);
        #1;
        check("done_single_pulse", 128'(done_cnt - d0), 128'd1);
        check("busy_after_done", 128'(busy), 128'd0);
        check("valid_after_done", 128'(pkt_if.out_valid), 128'd0);
`ifdef PKT_COUNT_EN
        check("pkt_count", 128'(pkt_count), 128'(exp_n));
`endif
        exp_q.delete();
    endtask

    initial begin
        int quiet;
        int exp_n;
        rst = 1'b1; start = 1'b0;
        cfg_channel = 8'd0; cfg_num_pus = 7'd0; cfg_filter_base = 8'd0; cfg_send_bias = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 128'(pkt_if.out_valid), 128'd0);
        check("rst_data", pkt_if.out_data, 128'd0);
        rst = 1'b0;

        // idle after reset
        quiet = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (pkt_if.out_valid || busy || done || weight_rd_en || bias_rd_en || img_rd_en) quiet++;
        end
        check("idle_activity", 128'(quiet), 128'd0);
        check("idle_addr", 128'({weight_rd_addr, bias_rd_addr, img_rd_addr}), 128'd0);

        // full load, always ready
        do_load(8'd1, 7'd2, 8'd5, 1'b1, 0, -1);
        // same load, ready toggling, with an ignored start mid-load
        do_load(8'd1, 7'd2, 8'd5, 1'b1, 1, 20);
        // no PUs: image only
        do_load(8'd0, 7'd0, 8'd9, 1'b1, 0, -1);
        // all PUs, no bias, random backpressure, filter_id wraps
        do_load(8'd2, 7'd64, 8'd200, 1'b0, 2, -1);

        // reset in the middle of the image phase
        begin_load(8'd3, 7'd3, 8'd0, 1'b1, 0, exp_n);
        for (int c = 0; c < 2000 && acc_cnt < 52; c++) @(posedge clk);
        check("reached_idx40", 128'(acc_cnt >= 52), 128'd1);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_valid", 128'(pkt_if.out_valid), 128'd0);
        check("midrst_busy", 128'(busy), 128'd0);
        check("midrst_rd_en", 128'({weight_rd_en, bias_rd_en, img_rd_en}), 128'd0);
`ifdef PKT_COUNT_EN
        check("midrst_pkt_count", 128'(pkt_count), 128'd0);
`endif
        exp_q.delete();
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("post_rst_busy", 128'(busy), 128'd0);

        // restart begins again with the weight phase
        do_load(8'd1, 7'd2, 8'd5, 1'b1, 0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
